simprisc_mem_arbiter: RTL

Arbitrates the single simprisc memory port between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write with byte strobes). It accepts one request at a time, issues it to memory over a valid/ready handshake, and routes the response back to the owning requester. It enforces a starvation guard for IF and a response timeout. It sits between the core's fetch/LSU front ends and the memory model driven by the bench's load/store agents.

---
 rtl/simprisc_mem_arbiter_if.sv | 53 +++++
 rtl/simprisc_mem_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/simprisc_mem_arbiter_if.sv
// Request/response bundle shared by the IF front end, the LS front end and
// the memory port. The arbiter takes the slave view; the environment
// (front ends plus memory model) takes the master view.
interface simprisc_mem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   // instruction-fetch requester
   logic            if_req_valid;
   logic            if_req_ready;
   logic [AW-1:0]   if_addr;
   logic            if_rsp_valid;
   logic [DW-1:0]   if_rsp_data;
   logic            if_rsp_err;
   // load/store requester
   logic            ls_req_valid;
   logic            ls_req_ready;
   logic [AW-1:0]   ls_addr;
   logic            ls_we;
   logic [DW-1:0]   ls_wdata;
   logic [DW/8-1:0] ls_wstrb;
   logic            ls_rsp_valid;
   logic [DW-1:0]   ls_rsp_data;
   logic            ls_rsp_err;
   // memory port
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [AW-1:0]   mem_addr;
   logic            mem_we;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wstrb;
   logic            mem_rsp_valid;
   logic [DW-1:0]   mem_rsp_data;
   logic            mem_rsp_err;

   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  ls_req_valid, ls_addr, ls_we, ls_wdata, ls_wstrb,
      output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
   );

   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output ls_req_valid, ls_addr, ls_we, ls_wdata, ls_wstrb,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
   );
endinterface

// File: rtl/simprisc_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (read-only) and
// load/store. One transaction in flight; LS wins contests unless IF has been
// passed over STARVE_LIMIT times in a row. WAIT gives up after TIMEOUT cycles.
module simprisc_mem_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   simprisc_mem_arbiter_if.slave  bus,
   output logic                   busy,
   output logic                   stray_rsp
);
   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t          state, state_nxt;
   logic            grant_if, grant_ls;
   logic            rsp_take, tmo_fire;

   logic            owner_ls;
   logic [AW-1:0]   addr_q;
   logic            we_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] wstrb_q;
   logic [SW-1:0]   starve_cnt;
   logic [TW-1:0]   tmo_cnt;

   logic            if_rsp_valid_q, ls_rsp_valid_q;
   logic [DW-1:0]   if_rsp_data_q, ls_rsp_data_q;
   logic            if_rsp_err_q, ls_rsp_err_q;
   logic            stray_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Grant selection and next-state; ready is gated by rst_n so it reads 0 during reset
   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_ls  = 1'b0;
      rsp_take  = 1'b0;
      tmo_fire  = 1'b0;
      case (state)
         S_IDLE: begin
            if (rst_n) begin
               if (bus.if_req_valid && bus.ls_req_valid) begin
                  if (starve_cnt == STARVE_MAX) grant_if = 1'b1;
                  else                          grant_ls = 1'b1;
               end else if (bus.if_req_valid) begin
                  grant_if = 1'b1;
               end else if (bus.ls_req_valid) begin
                  grant_ls = 1'b1;
               end
            end
            if (grant_if || grant_ls) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.mem_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            rsp_take = bus.mem_rsp_valid;
            tmo_fire = !bus.mem_rsp_valid && (tmo_cnt == TMO_LAST);
            if (rsp_take || tmo_fire) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request latch, starvation/timeout counters, registered responses, stray flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_ls       <= 1'b0;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         starve_cnt     <= '0;
         tmo_cnt        <= '0;
         if_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= '0;
         if_rsp_err_q   <= 1'b0;
         ls_rsp_valid_q <= 1'b0;
         ls_rsp_data_q  <= '0;
         ls_rsp_err_q   <= 1'b0;
         stray_q        <= 1'b0;
      end else begin
         if_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= '0;
         if_rsp_err_q   <= 1'b0;
         ls_rsp_valid_q <= 1'b0;
         ls_rsp_data_q  <= '0;
         ls_rsp_err_q   <= 1'b0;

         if (grant_if || grant_ls) begin
            owner_ls <= grant_ls;
            addr_q   <= grant_ls ? bus.ls_addr : bus.if_addr;
            we_q     <= grant_ls && bus.ls_we;
            wdata_q  <= grant_ls ? bus.ls_wdata : '0;
            wstrb_q  <= (grant_ls && bus.ls_we) ? bus.ls_wstrb : '0;
            if (grant_if)
               starve_cnt <= '0;
            else if (bus.if_req_valid && starve_cnt != STARVE_MAX)
               starve_cnt <= starve_cnt + 1'b1;
         end

         if (state == S_ISSUE && bus.mem_req_ready) tmo_cnt <= '0;
         else if (state == S_WAIT)                  tmo_cnt <= tmo_cnt + 1'b1;

         if (rsp_take) begin
            if (owner_ls) begin
               ls_rsp_valid_q <= 1'b1;
               ls_rsp_data_q  <= we_q ? '0 : bus.mem_rsp_data;
               ls_rsp_err_q   <= bus.mem_rsp_err;
            end else begin
               if_rsp_valid_q <= 1'b1;
               if_rsp_data_q  <= bus.mem_rsp_data;
               if_rsp_err_q   <= bus.mem_rsp_err;
            end
         end else if (tmo_fire) begin
            if (owner_ls) begin
               ls_rsp_valid_q <= 1'b1;
               ls_rsp_err_q   <= 1'b1;
            end else begin
               if_rsp_valid_q <= 1'b1;
               if_rsp_err_q   <= 1'b1;
            end
         end

         if (bus.mem_rsp_valid && state != S_WAIT) stray_q <= 1'b1;
      end
   end

   assign bus.if_req_ready  = grant_if;
   assign bus.ls_req_ready  = grant_ls;
   assign bus.if_rsp_valid  = if_rsp_valid_q;
   assign bus.if_rsp_data   = if_rsp_data_q;
   assign bus.if_rsp_err    = if_rsp_err_q;
   assign bus.ls_rsp_valid  = ls_rsp_valid_q;
   assign bus.ls_rsp_data   = ls_rsp_data_q;
   assign bus.ls_rsp_err    = ls_rsp_err_q;
   assign bus.mem_req_valid = (state == S_ISSUE);
   assign bus.mem_addr      = addr_q;
   assign bus.mem_we        = we_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wstrb     = wstrb_q;
   assign busy              = (state != S_IDLE);
   assign stray_rsp         = stray_q;
endmodule
